xmem_stream_ctrl: RTL and testbench

//  Initiator for the 256x32 dual-port xmem: turns valid/ready streams into port accesses.

---
 rtl/xmem_stream_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_xmem_stream_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/xmem_stream_ctrl.sv
// Stream-to-memory initiator for a dual-port xmem: a write engine on port 0 fed by a
// valid/ready input stream, and a read engine on port 1 draining through a 2-entry FIFO.
module xmem_stream_ctrl #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 32
) (
  input  logic          CLK,
  input  logic          RESET,
  // write engine
  input  logic          wr_start,
  input  logic [AW-1:0] wr_base,
  input  logic [AW:0]   wr_len,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          wr_busy,
  output logic          wr_done,
  // read engine
  input  logic          rd_start,
  input  logic [AW-1:0] rd_base,
  input  logic [AW:0]   rd_len,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          rd_busy,
  output logic          rd_done,
  // memory port 0 (write)
  output logic          CEN0,
  output logic          WEN0,
  output logic [AW-1:0] A0,
  output logic [DW-1:0] D0,
  // memory port 1 (read)
  output logic          CEN1,
  output logic          WEN1,
  output logic [AW-1:0] A1,
  input  logic [DW-1:0] Q1
);

  typedef enum logic {WrIdle, WrRun} wr_state_e;
  typedef enum logic [1:0] {RdIdle, RdIssue, RdDrain} rd_state_e;

  wr_state_e     wr_state_q, wr_state_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [AW:0]   wr_cnt_q, wr_cnt_d;
  logic          wr_done_q, wr_done_d;
  logic          wr_fire;

  rd_state_e     rd_state_q, rd_state_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic [AW:0]   rd_rem_q, rd_rem_d;
  logic          rd_done_q, rd_done_d;
  logic          inflight_q;
  logic          issue, push, pop;
  logic [2:0]    occ_proj;

  logic [DW-1:0] fifo_q [2];
  logic          fifo_wptr_q, fifo_rptr_q;
  logic [1:0]    occ_q, occ_d;

  // ---------------- write engine ----------------
  always_comb begin
    wr_state_d = wr_state_q;
    wr_addr_d  = wr_addr_q;
    wr_cnt_d   = wr_cnt_q;
    wr_done_d  = 1'b0;
    wr_fire    = 1'b0;
    unique case (wr_state_q)
      WrIdle: begin
        if (wr_start) begin
          if (wr_len != '0) begin
            wr_state_d = WrRun;
            wr_addr_d  = wr_base;
            wr_cnt_d   = wr_len;
          end else begin
            wr_done_d = 1'b1;
          end
        end
      end
      WrRun: begin
        wr_fire = in_valid;
        if (in_valid) begin
          wr_addr_d = wr_addr_q + AW'(1);
          wr_cnt_d  = wr_cnt_q - (AW+1)'(1);
          if (wr_cnt_q == (AW+1)'(1)) begin
            wr_state_d = WrIdle;
            wr_done_d  = 1'b1;
          end
        end
      end
      default: wr_state_d = WrIdle;
    endcase
  end

  assign in_ready = (wr_state_q == WrRun);
  assign wr_busy  = (wr_state_q == WrRun);
  assign wr_done  = wr_done_q;
  assign CEN0     = ~wr_fire;
  assign WEN0     = ~wr_fire;
  assign A0       = wr_addr_q;
  assign D0       = in_data;

  // ---------------- read engine ----------------
  assign pop       = out_valid & out_ready;
  assign push      = inflight_q;
  // Occupancy after this cycle's pop, counting the word still in flight from the memory.
  assign occ_proj  = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue     = (rd_state_q == RdIssue) && (rd_rem_q != '0) && (occ_proj < 3'd2);
  assign occ_d     = occ_q + {1'b0, push} - {1'b0, pop};

  always_comb begin
    rd_state_d = rd_state_q;
    rd_addr_d  = rd_addr_q;
    rd_rem_d   = rd_rem_q;
    rd_done_d  = 1'b0;
    unique case (rd_state_q)
      RdIdle: begin
        if (rd_start) begin
          if (rd_len != '0) begin
            rd_state_d = RdIssue;
            rd_addr_d  = rd_base;
            rd_rem_d   = rd_len;
          end else begin
            rd_done_d = 1'b1;
          end
        end
      end
      RdIssue: begin
        if (issue) begin
          rd_addr_d = rd_addr_q + AW'(1);
          rd_rem_d  = rd_rem_q - (AW+1)'(1);
          if (rd_rem_q == (AW+1)'(1)) rd_state_d = RdDrain;
        end
      end
      RdDrain: begin
        if (!inflight_q && pop && (occ_q == 2'd1)) begin
          rd_state_d = RdIdle;
          rd_done_d  = 1'b1;
        end
      end
      default: rd_state_d = RdIdle;
    endcase
  end

  assign out_valid = (occ_q != 2'd0);
  assign out_data  = fifo_q[fifo_rptr_q];
  assign rd_busy   = (rd_state_q != RdIdle);
  assign rd_done   = rd_done_q;
  assign CEN1      = ~issue;
  assign WEN1      = 1'b1;
  assign A1        = rd_addr_q;

  // ---------------- state ----------------
  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_state_q  <= WrIdle;
      wr_addr_q   <= '0;
      wr_cnt_q    <= '0;
      wr_done_q   <= 1'b0;
      rd_state_q  <= RdIdle;
      rd_addr_q   <= '0;
      rd_rem_q    <= '0;
      rd_done_q   <= 1'b0;
      inflight_q  <= 1'b0;
      occ_q       <= 2'd0;
      fifo_wptr_q <= 1'b0;
      fifo_rptr_q <= 1'b0;
    end else begin
      wr_state_q  <= wr_state_d;
      wr_addr_q   <= wr_addr_d;
      wr_cnt_q    <= wr_cnt_d;
      wr_done_q   <= wr_done_d;
      rd_state_q  <= rd_state_d;
      rd_addr_q   <= rd_addr_d;
      rd_rem_q    <= rd_rem_d;
      rd_done_q   <= rd_done_d;
      inflight_q  <= issue;
      occ_q       <= occ_d;
      if (push) fifo_wptr_q <= ~fifo_wptr_q;
      if (pop)  fifo_rptr_q <= ~fifo_rptr_q;
    end
  end

  // FIFO payload needs no reset; out_valid masks stale entries.
  always_ff @(posedge CLK) begin
    if (push) fifo_q[fifo_wptr_q] <= Q1;
  end

endmodule

// File: tb/tb_xmem_stream_ctrl.sv
// Self-checking bench for xmem_stream_ctrl: behavioural xmem, reference memory image,
// directed and randomized bursts on both engines.
module tb_xmem_stream_ctrl;

  localparam int AW = 8;
  localparam int DW = 32;

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic          wr_start = 1'b0;
  logic [AW-1:0] wr_base = '0;
  logic [AW:0]   wr_len = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          wr_busy, wr_done;
  logic          rd_start = 1'b0;
  logic [AW-1:0] rd_base = '0;
  logic [AW:0]   rd_len = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic          rd_busy, rd_done;
  logic          CEN0, WEN0, CEN1, WEN1;
  logic [AW-1:0] A0, A1;
  logic [DW-1:0] D0;
  logic [DW-1:0] Q1 = '0;

  xmem_stream_ctrl #(.AW(AW), .DW(DW)) dut (
    .CLK(CLK), .RESET(RESET),
    .wr_start(wr_start), .wr_base(wr_base), .wr_len(wr_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .wr_busy(wr_busy), .wr_done(wr_done),
    .rd_start(rd_start), .rd_base(rd_base), .rd_len(rd_len),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .rd_busy(rd_busy), .rd_done(rd_done),
    .CEN0(CEN0), .WEN0(WEN0), .A0(A0), .D0(D0),
    .CEN1(CEN1), .WEN1(WEN1), .A1(A1), .Q1(Q1)
  );

  always #5 CLK = ~CLK;

  // Behavioural 256x32 dual-port memory, write-first on address collision.
  logic [DW-1:0] xmem [256];
  always @(posedge CLK) begin
    if (!CEN0 && !WEN0) xmem[A0] <= D0;
    if (!CEN1) Q1 <= (!CEN0 && !WEN0 && (A0 == A1)) ? D0 : xmem[A1];
  end

  int n_cen0 = 0;
  int n_cen1 = 0;
  always @(posedge CLK) begin
    if (!RESET && !CEN0) n_cen0 <= n_cen0 + 1;
    if (!RESET && !CEN1) n_cen1 <= n_cen1 + 1;
  end

  logic [DW-1:0] ref_mem [256];
  int n_chk = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // seq=1 writes 0xA0+i, otherwise random words.
  task automatic do_write(input int base, input int len, input int valid_pct,
                          input bit disturb, input bit seq);
    int i, cyc, c0;
    logic [DW-1:0] w;
    bit hs;
    c0 = n_cen0;
    @(negedge CLK);
    wr_start = 1'b1; wr_base = base[7:0]; wr_len = len[8:0];
    @(negedge CLK);
    wr_start = 1'b0;
    i = 0; cyc = 0;
    w = seq ? 32'hA0 : $urandom;
    while (i < len && cyc < 4000) begin
      if (disturb && cyc == 1) begin
        wr_start = 1'b1; wr_base = 8'hEE; wr_len = 9'd3;
      end else begin
        wr_start = 1'b0;
      end
      in_valid = ($urandom_range(99) < valid_pct);
      in_data  = w;
      #1;
      if (cyc == 0) check_val("in_ready_run", in_ready, 1);
      hs = in_valid && in_ready;
      @(negedge CLK);
      cyc++;
      if (hs) begin
        ref_mem[(base + i) % 256] = w;
        i++;
        w = seq ? 32'hA0 + i : $urandom;
      end
    end
    in_valid = 1'b0; wr_start = 1'b0;
    check_val("wr_words", i, len);
    if (valid_pct >= 100) check_val("wr_cycles", cyc, len);
    check_val("wr_done", wr_done, 1);
    check_val("wr_busy_end", wr_busy, 0);
    check_val("in_ready_idle", in_ready, 0);
    check_val("wr_access_cnt", n_cen0 - c0, len);
    @(negedge CLK);
    check_val("wr_done_pulse", wr_done, 0);
  endtask

  // mode: 0 ready always, 1 ready toggling, 2 ready random
  task automatic do_read(input int base, input int len, input int mode, input bit disturb);
    int n, cyc, first, c1;
    logic [DW-1:0] held;
    bit stalled;
    c1 = n_cen1;
    @(negedge CLK);
    rd_start = 1'b1; rd_base = base[7:0]; rd_len = len[8:0];
    @(negedge CLK);
    rd_start = 1'b0;
    n = 0; cyc = 0; first = -1; stalled = 1'b0; held = '0;
    while (n < len && cyc < 4000) begin
      if (disturb && cyc == 1) begin
        rd_start = 1'b1; rd_base = 8'h00; rd_len = 9'd5;
      end else begin
        rd_start = 1'b0;
      end
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ((cyc % 2) == 0);
        default: out_ready = ($urandom_range(1) == 1);
      endcase
      #1;
      if (stalled) check_val("out_hold", {out_valid, out_data}, {1'b1, held});
      if (out_valid && first < 0) first = cyc;
      if (out_valid && out_ready) begin
        check_val("rd_data", out_data, ref_mem[(base + n) % 256]);
        n++;
      end
      stalled = out_valid && !out_ready;
      held    = out_data;
      @(negedge CLK);
      cyc++;
    end
    rd_start = 1'b0; out_ready = 1'b0;
    check_val("rd_words", n, len);
    if (mode == 0 && len > 0) begin
      check_val("rd_first_valid", first, 2);
      check_val("rd_cycles", cyc, len + 2);
    end
    check_val("rd_done", rd_done, 1);
    check_val("rd_busy_end", rd_busy, 0);
    check_val("out_valid_end", out_valid, 0);
    check_val("rd_access_cnt", n_cen1 - c1, len);
    @(negedge CLK);
    check_val("rd_done_pulse", rd_done, 0);
  endtask

  initial begin
    int b, l, rb, rl;
    bit seen_done;

    repeat (3) @(negedge CLK);
    check_val("rst_busy", {wr_busy, rd_busy}, 0);
    check_val("rst_done", {wr_done, rd_done}, 0);
    check_val("rst_valid_ready", {out_valid, in_ready}, 0);
    check_val("rst_enables", {CEN0, WEN0, CEN1, WEN1}, 4'hF);
    check_val("rst_addr", {A0, A1}, 0);
    RESET = 1'b0;

    do_write(32'h10, 4, 100, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) check_val("mem_A0", xmem[8'h10 + k], 32'hA0 + k);
    do_read(32'h10, 4, 0, 1'b0);

    do_write(32'h80, 256, 100, 1'b0, 1'b0);
    do_read(32'h80, 256, 0, 1'b0);
    do_read(32'hFC, 8, 1, 1'b0);

    do_write(32'h30, 0, 100, 1'b0, 1'b0);
    do_read(32'h30, 0, 0, 1'b0);

    do_write(32'h50, 10, 60, 1'b1, 1'b0);
    do_read(32'h50, 10, 2, 1'b1);

    fork
      do_write(32'h40, 16, 70, 1'b0, 1'b0);
      do_read(32'hC0, 16, 2, 1'b0);
    join

    repeat (6) begin
      b  = $urandom_range(255);
      l  = $urandom_range(24, 1);
      rb = $urandom_range(255);
      rl = $urandom_range(30, 0);
      do_write(b, l, $urandom_range(100, 30), 1'b0, 1'b0);
      do_read(b, l, 2, 1'b0);
      do_read(rb, rl, $urandom_range(2), 1'b0);
    end

    // Reset in the middle of an active read burst.
    @(negedge CLK);
    rd_start = 1'b1; rd_base = 8'h20; rd_len = 9'd8; out_ready = 1'b1;
    @(negedge CLK);
    rd_start = 1'b0;
    repeat (2) @(negedge CLK);
    #1;
    check_val("pre_rst_active", {out_valid, CEN1}, 2'b10);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    out_ready = 1'b0;
    check_val("midrst_valid", out_valid, 0);
    check_val("midrst_cen1", CEN1, 1);
    check_val("midrst_busy", rd_busy, 0);
    seen_done = rd_done;
    repeat (3) begin
      @(negedge CLK);
      seen_done = seen_done | rd_done;
    end
    check_val("midrst_no_done", seen_done, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
